dpd_stream_encoder: RTL and testbench

//  Streaming BCD -> DPD packer (IEEE 754-2008 densely packed decimal).

---
 rtl/dpd_stream_encoder_if.sv | 27 ++
 rtl/dpd_stream_encoder.sv | 141 ++++++++++++++
 tb/tb_dpd_stream_encoder.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dpd_stream_encoder_if.sv
// Digit-in / declet-out stream bundle for the DPD packer.
// master drives digits and out_ready; slave is the encoder.
`timescale 1ns/1ps
interface dpd_stream_encoder_if;
    logic [3:0] in_digit;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] out_declet;
    logic [1:0] out_ndig;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       bcd_err;

    modport master (
        output in_digit, in_last, in_valid, out_ready,
        input  in_ready, out_declet, out_ndig,
        input  out_last, out_valid, bcd_err
    );

    modport slave (
        input  in_digit, in_last, in_valid, out_ready,
        output in_ready, out_declet, out_ndig,
        output out_last, out_valid, bcd_err
    );
endinterface

// File: rtl/dpd_stream_encoder.sv
// Streaming BCD -> DPD packer: three digits (MSD first) per 10-bit declet.
// Ports: clk, rst (sync, active-high), s (slave side of the stream bundle).
`timescale 1ns/1ps
module dpd_stream_encoder #(
    parameter logic [3:0] PAD_DIGIT = 4'd0
) (
    input logic            clk,
    input logic            rst,
    dpd_stream_encoder_if.slave s
);

    logic [1:0] cnt_q, cnt_d;
    logic [3:0] d2_q, d2_d;
    logic [3:0] d1_q, d1_d;
    logic [9:0] declet_q, declet_d;
    logic [1:0] ndig_q, ndig_d;
    logic       last_q, last_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    logic       bad;
    logic       completing;
    logic       in_ready;
    logic       accept;
    logic       load;
    logic [3:0] digit;
    logic [3:0] g2, g1, g0;

    // Large digits (8/9) carry only their LSB; the (a,e,i) pattern
    // decides where the 3-bit fields of the small digits land.
    function automatic logic [9:0] dpd_enc(
        input logic [3:0] x2,
        input logic [3:0] x1,
        input logic [3:0] x0
    );
        logic [1:0] pq, st, wx;
        logic       v;
        pq = 2'b00;
        st = 2'b00;
        wx = 2'b00;
        v  = 1'b1;
        unique case ({x2[3], x1[3], x0[3]})
            3'b000: begin
                pq = x2[2:1]; st = x1[2:1]; v = 1'b0; wx = x0[2:1];
            end
            3'b001: begin
                pq = x2[2:1]; st = x1[2:1]; wx = 2'b00;
            end
            3'b010: begin
                pq = x2[2:1]; st = x0[2:1]; wx = 2'b01;
            end
            3'b100: begin
                pq = x0[2:1]; st = x1[2:1]; wx = 2'b10;
            end
            3'b110: begin
                pq = x0[2:1]; st = 2'b00; wx = 2'b11;
            end
            3'b101: begin
                pq = x1[2:1]; st = 2'b01; wx = 2'b11;
            end
            3'b011: begin
                pq = x2[2:1]; st = 2'b10; wx = 2'b11;
            end
            3'b111: begin
                pq = 2'b00; st = 2'b11; wx = 2'b11;
            end
        endcase
        return {pq, x2[0], st, x1[0], v, wx, x0[0]};
    endfunction

    always_comb begin
        bad        = s.in_digit > 4'd9;
        digit      = bad ? PAD_DIGIT : s.in_digit;
        completing = (cnt_q == 2'd2) | s.in_last;
        // Only a completing digit can be blocked by a full output register.
        in_ready   = !(completing & valid_q & !s.out_ready);
        accept     = s.in_valid & in_ready;
        load       = accept & completing;

        g2 = (cnt_q == 2'd0) ? digit : d2_q;
        g1 = (cnt_q == 2'd1) ? digit :
             (cnt_q == 2'd2) ? d1_q : PAD_DIGIT;
        g0 = (cnt_q == 2'd2) ? digit : PAD_DIGIT;

        cnt_d    = cnt_q;
        d2_d     = d2_q;
        d1_d     = d1_q;
        declet_d = declet_q;
        ndig_d   = ndig_q;
        last_d   = last_q;
        valid_d  = valid_q;
        err_d    = err_q | (accept & bad);

        if (valid_q & s.out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (cnt_q == 2'd0) d2_d = digit;
            if (cnt_q == 2'd1) d1_d = digit;
            cnt_d = completing ? 2'd0 : cnt_q + 2'd1;
        end

        if (load) begin
            declet_d = dpd_enc(g2, g1, g0);
            ndig_d   = cnt_q + 2'd1;
            last_d   = s.in_last;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 2'd0;
            d2_q     <= 4'd0;
            d1_q     <= 4'd0;
            declet_q <= 10'd0;
            ndig_q   <= 2'd0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            d2_q     <= d2_d;
            d1_q     <= d1_d;
            declet_q <= declet_d;
            ndig_q   <= ndig_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign s.in_ready   = in_ready;
    assign s.out_declet = declet_q;
    assign s.out_ndig   = ndig_q;
    assign s.out_last   = last_q;
    assign s.out_valid  = valid_q;
    assign s.bcd_err    = err_q;

endmodule

// File: tb/tb_dpd_stream_encoder.sv
// Self-checking bench for dpd_stream_encoder: directed vectors,
// stall/reset sequences, exhaustive triples and a random stream model.
`timescale 1ns/1ps
module tb_dpd_stream_encoder;

    localparam int PAD = 0;

    logic clk;
    logic rst;
    dpd_stream_encoder_if bus ();

    dpd_stream_encoder #(.PAD_DIGIT(4'(PAD))) dut (
        .clk(clk),
        .rst(rst),
        .s  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] d;
        logic [1:0] n;
        logic       l;
    } out_t;

    typedef struct packed {
        logic [11:0] dg;
        logic [1:0]  n;
        logic [9:0]  decl;
    } vec_t;

    int   n_chk;
    int   n_bad;
    out_t exp_q[$];
    out_t held;
    out_t mon_e;
    bit   mon_stall;
    bit   w;
    bit   wt[10];
    vec_t tv[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // DPD reference: digits 8/9 are "large" and contribute only their
    // parity; small digits contribute (value/2)%4 as a 2-bit field.
    function automatic logic [9:0] ref_dpd(input int x, input int y,
                                           input int z);
        int big, bx, by, bz, pq, st, v, wx;
        big = 0;
        if (x > 7) big += 4;
        if (y > 7) big += 2;
        if (z > 7) big += 1;
        bx = (x / 2) % 4;
        by = (y / 2) % 4;
        bz = (z / 2) % 4;
        v  = 1;
        case (big)
            0: begin pq = bx; st = by; v = 0; wx = bz; end
            1: begin pq = bx; st = by; wx = 0; end
            2: begin pq = bx; st = bz; wx = 1; end
            4: begin pq = bz; st = by; wx = 2; end
            6: begin pq = bz; st = 0;  wx = 3; end
            5: begin pq = by; st = 1;  wx = 3; end
            3: begin pq = bx; st = 2;  wx = 3; end
            default: begin pq = 0; st = 3; wx = 3; end
        endcase
        return 10'(pq * 256 + (x % 2) * 128 + st * 32 + (y % 2) * 16
                   + v * 8 + wx * 2 + (z % 2));
    endfunction

    task automatic expect_decl(input logic [9:0] d, input logic [1:0] n,
                               input logic l);
        out_t e;
        e.d = d;
        e.n = n;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Every handshake must match the next expected declet; a stalled
    // output must not change before it is consumed.
    always @(negedge clk) begin
        if (rst) begin
            mon_stall = 1'b0;
        end else begin
            if (mon_stall) begin
                chk("hold_stable",
                    32'({bus.out_valid, bus.out_declet, bus.out_ndig,
                         bus.out_last}),
                    32'({1'b1, held}));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_bad++;
                    $display("FAIL extra_declet: got=%0h want=none",
                             bus.out_declet);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("declet", 32'(bus.out_declet), 32'(mon_e.d));
                    chk("ndig", 32'(bus.out_ndig), 32'(mon_e.n));
                    chk("last", 32'(bus.out_last), 32'(mon_e.l));
                end
            end
            mon_stall = bus.out_valid && !bus.out_ready;
            held = {bus.out_declet, bus.out_ndig, bus.out_last};
        end
    end

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_digit = 4'd0;
    endtask

    // Entered and left at posedge+1; returns once the digit is accepted.
    task automatic push(input logic [3:0] dg, input bit lst,
                        output bit waited);
        bus.in_digit = dg;
        bus.in_last  = lst;
        bus.in_valid = 1'b1;
        waited = 1'b0;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
            waited = 1'b1;
            @(posedge clk);
            #1;
        end
        n_chk++;
        n_bad++;
        $display("FAIL push_timeout: got=no_ready want=ready digit=%0d", dg);
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (exp_q.size() == 0 && !bus.out_valid) return;
            @(posedge clk);
            #1;
        end
        n_chk++;
        n_bad++;
        $display("FAIL drain_timeout: got=%0d pending want=0", exp_q.size());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int   mgrp[$];
        bit   merr, occ, comp, exp_rdy, hs, ld;
        int   dg;

        n_chk = 0;
        n_bad = 0;
        tv[0] = '{12'h123, 2'd3, 10'h0A3};
        tv[1] = '{12'h999, 2'd3, 10'h0FF};
        tv[2] = '{12'h985, 2'd3, 10'h28F};
        tv[3] = '{12'h812, 2'd3, 10'h11C};
        tv[4] = '{12'h000, 2'd3, 10'h000};
        tv[5] = '{12'h700, 2'd1, 10'h380};
        tv[6] = '{12'h450, 2'd2, 10'h250};

        clk = 1'b0;
        rst = 1'b1;
        idle();
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_bcd_err", 32'(bus.bcd_err), 0);
        chk("rst_declet", 32'(bus.out_declet), 0);
        chk("rst_ndig", 32'(bus.out_ndig), 0);
        chk("rst_last", 32'(bus.out_last), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);

        // Latency: valid one cycle after the completing digit.
        bus.out_ready = 1'b1;
        push(4'd1, 1'b0, w);
        chk("lat_no_early_valid", 32'(bus.out_valid), 0);
        push(4'd2, 1'b0, w);
        push(4'd3, 1'b1, w);
        expect_decl(10'h0A3, 2'd3, 1'b1);
        idle();
        chk("lat_valid", 32'(bus.out_valid), 1);
        chk("lat_declet", 32'(bus.out_declet), 32'h0A3);
        @(posedge clk);
        #1;
        chk("lat_valid_clear", 32'(bus.out_valid), 0);

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < int'(tv[i].n); j++) begin
                push(tv[i].dg[11 - 4 * j -: 4], j == int'(tv[i].n) - 1, w);
            end
            expect_decl(tv[i].decl, tv[i].n, 1'b1);
            idle();
            chk("vec_valid", 32'(bus.out_valid), 1);
            chk("vec_declet", 32'(bus.out_declet), 32'(tv[i].decl));
            chk("vec_ndig", 32'(bus.out_ndig), 32'(tv[i].n));
            chk("vec_last", 32'(bus.out_last), 1);
            @(posedge clk);
            #1;
        end
        drain();

        // Stall: 456 -> 0x256, 789 -> 0x3CF from the encoding table.
        bus.out_ready = 1'b0;
        expect_decl(10'h0A3, 2'd3, 1'b0);
        expect_decl(10'h256, 2'd3, 1'b0);
        expect_decl(10'h3CF, 2'd3, 1'b1);
        fork
            begin
                for (int d = 1; d <= 9; d++) begin
                    push(4'(d), d == 9, w);
                    wt[d] = w;
                end
                idle();
            end
            begin
                for (int k = 0; k < 50 && !bus.out_valid; k++) begin
                    @(posedge clk);
                    #1;
                end
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        for (int d = 1; d <= 8; d++) begin
            if (d != 3 && d != 6) chk("stall_nc_ready", 32'(wt[d]), 0);
        end
        chk("stall_first_ready", 32'(wt[3]), 0);
        chk("stall_complete_blocked", 32'(wt[6]), 1);
        drain();

        // Illegal digit stored as pad, flag is sticky.
        push(4'hC, 1'b0, w);
        chk("err_set", 32'(bus.bcd_err), 1);
        push(4'd3, 1'b0, w);
        push(4'd4, 1'b1, w);
        expect_decl(10'h034, 2'd3, 1'b1);
        idle();
        repeat (10) @(posedge clk);
        #1;
        chk("err_sticky", 32'(bus.bcd_err), 1);
        drain();

        // Reset mid-group discards the partial group.
        push(4'd5, 1'b0, w);
        push(4'd6, 1'b0, w);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_valid", 32'(bus.out_valid), 0);
        chk("midrst_err", 32'(bus.bcd_err), 0);
        push(4'd1, 1'b0, w);
        push(4'd2, 1'b0, w);
        push(4'd3, 1'b1, w);
        expect_decl(10'h0A3, 2'd3, 1'b1);
        idle();
        drain();

        for (int t = 0; t < 1000; t++) begin
            push(4'(t / 100), 1'b0, w);
            push(4'((t / 10) % 10), 1'b0, w);
            push(4'(t % 10), 1'b1, w);
            expect_decl(ref_dpd(t / 100, (t / 10) % 10, t % 10), 2'd3, 1'b1);
        end
        idle();
        drain();

        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        merr = 1'b0;
        occ  = 1'b0;
        mgrp.delete();
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 9) == 0) dg = int'($urandom_range(10, 15));
            else dg = int'($urandom_range(0, 9));
            bus.in_digit  = 4'(dg);
            bus.in_last   = $urandom_range(0, 4) == 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            #1;
            chk("rnd_out_valid", 32'(bus.out_valid), 32'(occ));
            chk("rnd_bcd_err", 32'(bus.bcd_err), 32'(merr));
            comp    = mgrp.size() == 2 || bus.in_last;
            exp_rdy = !(comp && occ && !bus.out_ready);
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            hs = occ && bus.out_ready;
            ld = 1'b0;
            if (bus.in_valid && exp_rdy) begin
                if (dg > 9) merr = 1'b1;
                mgrp.push_back(dg > 9 ? PAD : dg);
                if (mgrp.size() == 3 || bus.in_last) begin
                    ld = 1'b1;
                    expect_decl(10'h000, 2'(mgrp.size()), bus.in_last);
                    while (mgrp.size() < 3) mgrp.push_back(PAD);
                    exp_q[exp_q.size() - 1].d =
                        ref_dpd(mgrp[0], mgrp[1], mgrp[2]);
                    mgrp.delete();
                end
            end
            occ = ld ? 1'b1 : (hs ? 1'b0 : occ);
            @(posedge clk);
            #1;
        end
        idle();
        bus.out_ready = 1'b1;
        drain();
        chk("leftover", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
